hazard_stall_controller: RTL and testbench

Pipeline hazard and freeze controller for one core. It sits directly upstream of the ID/EX control buffer and tells the front end and that buffer when to hold, when to flush, and when to load a bubble (all-zero control word) instead of the decoded controls. It resolves three conditions:

- load-use hazards, with a parameterised stall length;
- EX-stage redirects (taken branch or jump), with a parameterised flush depth;
- data-memory wait states.

It also keeps saturating performance counters.

---
 rtl/hazard_stall_controller.sv | 123 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard/freeze controller upstream of the ID/EX buffer: load-use stalls,
// redirect flushes, data-memory freezes, and saturating perf counters.
module hazard_stall_controller #(
    parameter int CORE              = 0,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memRead,
    input  logic        ex_regWrite,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  state,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {RUN = 2'd0, LOAD_USE = 2'd1, REDIRECT = 2'd2} state_t;

    // CORE only tags the instance; the zero product keeps it out of the logic.
    localparam logic [1:0] LS_M1 = 2'(LOAD_STALL_CYCLES - 1 + 0 * CORE);
    localparam logic [1:0] FL_M1 = 2'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  remain_q, remain_d;
    logic [15:0] stall_q, flush_q;

    logic load_use, mem_busy, redirect_acc;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c, pipe_freeze_c;

    assign load_use = ex_memRead & ex_regWrite & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign mem_busy = dmem_req & ~dmem_ready;

    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_freeze_c = 1'b0;
        redirect_acc  = 1'b0;
        if (mem_busy) begin
            pipe_freeze_c = 1'b1;
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
        end else begin
            case (state_q)
                RUN, LOAD_USE: begin
                    if (ex_redirect) begin
                        redirect_acc  = 1'b1;
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        remain_d      = FL_M1;
                        state_d       = (FL_M1 != 2'd0) ? REDIRECT : RUN;
                    end else if (state_q == LOAD_USE) begin
                        pc_stall_c    = 1'b1;
                        ifid_stall_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        remain_d      = remain_q - 2'd1;
                        state_d       = (remain_q == 2'd1) ? RUN : LOAD_USE;
                    end else if (load_use) begin
                        pc_stall_c    = 1'b1;
                        ifid_stall_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        remain_d      = LS_M1;
                        state_d       = (LS_M1 != 2'd0) ? LOAD_USE : RUN;
                    end
                end
                REDIRECT: begin
                    // EX holds a bubble here, so new redirects and load-use are moot.
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    remain_d      = remain_q - 2'd1;
                    state_d       = (remain_q == 2'd1) ? RUN : REDIRECT;
                end
                default: begin
                    state_d  = RUN;
                    remain_d = 2'd0;
                end
            endcase
        end
    end

    // Reset forces every control output low regardless of inputs.
    assign pc_stall    = reset & pc_stall_c;
    assign ifid_stall  = reset & ifid_stall_c;
    assign ifid_flush  = reset & ifid_flush_c;
    assign idex_bubble = reset & idex_bubble_c;
    assign pipe_freeze = reset & pipe_freeze_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            remain_q <= 2'd0;
            stall_q  <= 16'd0;
            flush_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            if (pc_stall_c && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (redirect_acc && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboarded bench: default instance (a) and a LOAD_STALL_CYCLES=3 instance (b) share stimulus.
module tb_hazard_stall_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_memRead, ex_regWrite, ex_redirect, dmem_req, dmem_ready;

    logic a_pc, a_ifs, a_iff, a_bub, a_frz;
    logic b_pc, b_ifs, b_iff, b_bub, b_frz;
    logic [1:0]  a_state, b_state;
    logic [15:0] a_stall, a_flush, b_stall, b_flush;
    logic [6:0]  obs_a, obs_b;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, state}
    localparam logic [6:0] NONE      = 7'b0000000;
    localparam logic [6:0] STALL_RUN = 7'b1101000;
    localparam logic [6:0] STALL_LU  = 7'b1101001;
    localparam logic [6:0] FLUSH_RUN = 7'b0011000;
    localparam logic [6:0] FLUSH_LU  = 7'b0011001;
    localparam logic [6:0] FLUSH_RD  = 7'b0011010;
    localparam logic [6:0] FRZ_LU    = 7'b1100101;

    localparam int S_IDLE = 0, S_LU = 1, S_LU2 = 2, S_X0 = 3, S_RS2OFF = 4, S_NOLOAD = 5,
                   S_RDIR = 6, S_LU_RDIR = 7, S_FRZ = 8, S_MEMOK = 9, S_ALL = 10;

    assign obs_a = {a_pc, a_ifs, a_iff, a_bub, a_frz, a_state};
    assign obs_b = {b_pc, b_ifs, b_iff, b_bub, b_frz, b_state};

    always #5 clock = ~clock;

    hazard_stall_controller u_a (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(a_pc), .ifid_stall(a_ifs), .ifid_flush(a_iff), .idex_bubble(a_bub),
        .pipe_freeze(a_frz), .state(a_state), .stall_cycles(a_stall), .flush_events(a_flush)
    );

    hazard_stall_controller #(.CORE(1), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_b (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(b_pc), .ifid_stall(b_ifs), .ifid_flush(b_iff), .idex_bubble(b_bub),
        .pipe_freeze(b_frz), .state(b_state), .stall_cycles(b_stall), .flush_events(b_flush)
    );

    task automatic apply(input int code);
        ex_memRead = 0; ex_regWrite = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_redirect = 0; dmem_req = 0; dmem_ready = 0;
        case (code)
            S_LU:      begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; end
            S_LU2:     begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
                             id_rs1 = 3; id_uses_rs1 = 1; end
            S_X0:      begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; end
            S_RS2OFF:  begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
                             id_rs1 = 4; id_uses_rs1 = 1; end
            S_NOLOAD:  begin ex_regWrite = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; end
            S_RDIR:    ex_redirect = 1;
            S_LU_RDIR: begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
                             ex_redirect = 1; end
            S_FRZ:     dmem_req = 1;
            S_MEMOK:   begin dmem_req = 1; dmem_ready = 1; end
            S_ALL:     begin ex_memRead = 1; ex_regWrite = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
                             ex_redirect = 1; dmem_req = 1; end
            default:   ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        apply(S_IDLE);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        reset = 1'b0;
        apply(S_ALL);
        exp_q.push_back(NONE);
        repeat (2) @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs_a !== e) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs_a, e); end
        checks++;
        if (a_stall !== 16'd0 || a_flush !== 16'd0)
            begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", a_stall, a_flush); end
        checks++;
        if (obs_b !== NONE) begin errors++; $display("FAIL reset_outputs_b: got %b expected %b", obs_b, NONE); end
        @(posedge clock);
        #1 reset = 1'b1;
        apply(S_IDLE);
    endtask

    task automatic test_load_use();
        int stim [4];
        logic [6:0] expv [4];
        logic [6:0] e;
        stim = '{S_LU, S_IDLE, S_LU2, S_IDLE};
        expv = '{STALL_RUN, NONE, STALL_RUN, NONE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs_a, e); end
            @(posedge clock);
            #1;
            if (i == 1) begin
                checks++;
                if (a_stall !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", a_stall); end
            end
        end
        checks++;
        if (a_stall !== 16'd2) begin errors++; $display("FAIL load_use_count2: got %0d expected 2", a_stall); end
    endtask

    task automatic test_no_stall();
        int stim [4];
        logic [6:0] e;
        stim = '{S_X0, S_RS2OFF, S_NOLOAD, S_MEMOK};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            exp_q.push_back(NONE);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL no_stall[%0d]: got %b expected %b", i, obs_a, e); end
            @(posedge clock);
            #1;
        end
        checks++;
        if (a_stall !== 16'd0) begin errors++; $display("FAIL no_stall_count: got %0d expected 0", a_stall); end
    endtask

    task automatic test_redirect();
        int stim [3];
        logic [6:0] expv [3];
        logic [6:0] e;
        stim = '{S_RDIR, S_IDLE, S_IDLE};
        expv = '{FLUSH_RUN, FLUSH_RD, NONE};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL redirect[%0d]: got %b expected %b", i, obs_a, e); end
            @(posedge clock);
            #1;
        end
        checks++;
        if (a_flush !== 16'd1 || a_stall !== 16'd0)
            begin errors++; $display("FAIL redirect_counts: got %0d/%0d expected 1/0", a_flush, a_stall); end
    endtask

    task automatic test_freeze();
        int stim [8];
        logic [6:0] expv [8];
        logic [6:0] e;
        stim = '{S_LU, S_FRZ, S_FRZ, S_FRZ, S_FRZ, S_IDLE, S_IDLE, S_MEMOK};
        expv = '{STALL_RUN, FRZ_LU, FRZ_LU, FRZ_LU, FRZ_LU, STALL_LU, STALL_LU, NONE};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin errors++; $display("FAIL freeze[%0d]: got %b expected %b", i, obs_b, e); end
            @(posedge clock);
            #1;
        end
        checks++;
        if (b_stall !== 16'd7) begin errors++; $display("FAIL freeze_count: got %0d expected 7", b_stall); end
    endtask

    task automatic test_simultaneous();
        int stim [4];
        logic [6:0] expv [4];
        logic [6:0] e;
        stim = '{S_LU_RDIR, S_IDLE, S_IDLE, S_IDLE};
        expv = '{FLUSH_RUN, FLUSH_RD, NONE, NONE};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_a !== e) begin errors++; $display("FAIL simul[%0d]: got %b expected %b", i, obs_a, e); end
            @(posedge clock);
            #1;
        end
        checks++;
        if (a_stall !== 16'd0) begin errors++; $display("FAIL simul_count: got %0d expected 0", a_stall); end
        stim = '{S_LU, S_RDIR, S_IDLE, S_IDLE};
        expv = '{STALL_RUN, FLUSH_LU, FLUSH_RD, NONE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (obs_b !== e) begin errors++; $display("FAIL lu_redirect[%0d]: got %b expected %b", i, obs_b, e); end
            @(posedge clock);
            #1;
        end
        checks++;
        if (b_flush !== 16'd1 || b_stall !== 16'd1)
            begin errors++; $display("FAIL lu_redirect_counts: got %0d/%0d expected 1/1", b_flush, b_stall); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e;
        do_reset();
        apply(S_RDIR);
        exp_q.push_back(FLUSH_RUN);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs_a !== e) begin errors++; $display("FAIL rst_mid_pre: got %b expected %b", obs_a, e); end
        @(posedge clock);
        #1;
        exp_q.push_back(FLUSH_RD);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs_a !== e) begin errors++; $display("FAIL rst_mid_rd: got %b expected %b", obs_a, e); end
        #1 reset = 1'b0;
        exp_q.push_back(NONE);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs_a !== e) begin errors++; $display("FAIL rst_mid_abort: got %b expected %b", obs_a, e); end
        @(posedge clock);
        #1 reset = 1'b1;
        apply(S_IDLE);
        exp_q.push_back(NONE);
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (obs_a !== e) begin errors++; $display("FAIL rst_mid_after: got %b expected %b", obs_a, e); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        apply(S_LU);
        repeat (65534) @(posedge clock);
        #1;
        checks++;
        if (a_stall !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", a_stall); end
        @(posedge clock);
        #1;
        checks++;
        if (a_stall !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected ffff", a_stall); end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (a_stall !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", a_stall); end
        apply(S_IDLE);
    endtask

    initial begin
        apply(S_IDLE);
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_freeze();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
